rfetch_bypass_stage: RTL and testbench

Parametrised register-fetch stage, successor to the fixed-width stall-driven fetch stage. It sits between decode and execute: holds one instruction in a valid/ready pipeline slot, reads rs1/rs2 from an internal register file, and forwards same-cycle writebacks from several writeback ports. An optional scoreboard interlocks issue against in-flight writers.

---
 rtl/rfetch_bypass_stage.sv | 170 +++++++++++++++++
 tb/tb_rfetch_bypass_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfetch_bypass_stage.sv
// Register-fetch stage: one valid/ready slot, register file with multi-port writeback bypass.
// Define RFETCH_SCOREBOARD_EN to interlock issue against in-flight writers.
package rvga_pkg;

  typedef enum logic [2:0] {
    IT_R = 3'd0,
    IT_I = 3'd1,
    IT_S = 3'd2,
    IT_B = 3'd3,
    IT_U = 3'd4,
    IT_J = 3'd5
  } rvga_itype_e;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_w_v;
    rvga_itype_e inst_type;
    logic        shift_v;
    logic        br_v;
    logic        jmp_v;
  } rvga_cword;

  // raw holds instruction bits [31:7], so inst[k] == raw[k-7]
  function automatic logic [31:0] rvga_imm(input rvga_itype_e t, input logic [24:0] raw,
                                           input logic shift_v);
    logic [31:0] imm;
    imm = '0;
    case (t)
      IT_I:    imm = shift_v ? {27'b0, raw[17:13]} : {{20{raw[24]}}, raw[24:13]};
      IT_S:    imm = {{20{raw[24]}}, raw[24:18], raw[4:0]};
      IT_B:    imm = {{19{raw[24]}}, raw[24], raw[0], raw[23:18], raw[4:1], 1'b0};
      IT_U:    imm = {raw[24:5], 12'b0};
      IT_J:    imm = {{11{raw[24]}}, raw[24], raw[12:5], raw[13], raw[23:14], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

module rfetch_bypass_stage
  import rvga_pkg::*;
#(
  parameter  int unsigned width_p    = 32,
  parameter  int unsigned els_p      = 32,
  parameter  int unsigned wb_ports_p = 2,
  localparam int unsigned reg_w      = $clog2(els_p)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          v_i,
  output logic                          ready_o,
  input  rvga_cword                     cword_i,
  input  logic [24:0]                   imm_raw_i,
  output logic                          v_o,
  input  logic                          ready_i,
  output rvga_cword                     cword_o,
  output logic [width_p-1:0]            imm_data_o,
  output logic [width_p-1:0]            rs1_data_o,
  output logic [width_p-1:0]            rs2_data_o,
  output logic                          br_v_o,
  input  logic                          flush_i,
  input  logic [wb_ports_p-1:0]         wb_v_i,
  input  logic [wb_ports_p*reg_w-1:0]   wb_rd_i,
  input  logic [wb_ports_p*width_p-1:0] wb_data_i
);

  logic                  valid_r;
  rvga_cword             cword_r;
  logic [24:0]           imm_r;
  logic [width_p-1:0]    rf_r [els_p];

  logic [reg_w-1:0]      wb_rd   [wb_ports_p];
  logic [width_p-1:0]    wb_data [wb_ports_p];
  logic [reg_w-1:0]      rs1_idx;
  logic [reg_w-1:0]      rs2_idx;
  logic [wb_ports_p-1:0] rs1_hit;
  logic [wb_ports_p-1:0] rs2_hit;
  logic                  hazard;
  logic                  accept;
  logic                  issue;
  logic signed [31:0]    imm32;

  always_comb begin
    for (int unsigned p = 0; p < wb_ports_p; p++) begin
      wb_rd[p]   = wb_rd_i[p*reg_w +: reg_w];
      wb_data[p] = wb_data_i[p*width_p +: width_p];
    end
  end

  assign rs1_idx = reg_w'(cword_r.rs1);
  assign rs2_idx = reg_w'(cword_r.rs2);

  // Ports scanned in ascending order so the highest-indexed writer of a register wins.
  always_comb begin
    rs1_hit    = '0;
    rs2_hit    = '0;
    rs1_data_o = rf_r[rs1_idx];
    rs2_data_o = rf_r[rs2_idx];
    for (int unsigned p = 0; p < wb_ports_p; p++) begin
      rs1_hit[p] = wb_v_i[p] && (wb_rd[p] == rs1_idx) && (rs1_idx != '0);
      rs2_hit[p] = wb_v_i[p] && (wb_rd[p] == rs2_idx) && (rs2_idx != '0);
      if (rs1_hit[p]) rs1_data_o = wb_data[p];
      if (rs2_hit[p]) rs2_data_o = wb_data[p];
    end
  end

  assign v_o     = valid_r & ~hazard;
  assign ready_o = ~flush_i & (~valid_r | (v_o & ready_i));
  assign accept  = v_i & ready_o;
  assign issue   = v_o & ready_i;
  assign br_v_o  = v_o & (cword_r.br_v | cword_r.jmp_v);
  assign cword_o = cword_r;

  assign imm32      = rvga_imm(cword_r.inst_type, imm_r, cword_r.shift_v);
  assign imm_data_o = width_p'(imm32);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_r <= 1'b0;
      cword_r <= '0;
      imm_r   <= '0;
    end else begin
      if (accept) begin
        cword_r <= cword_i;
        imm_r   <= imm_raw_i;
      end
      if (flush_i)     valid_r <= 1'b0;
      else if (accept) valid_r <= 1'b1;
      else if (issue)  valid_r <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < els_p; i++) rf_r[i] <= '0;
    end else begin
      for (int unsigned p = 0; p < wb_ports_p; p++) begin
        if (wb_v_i[p] && (wb_rd[p] != '0)) rf_r[wb_rd[p]] <= wb_data[p];
      end
    end
  end

`ifdef RFETCH_SCOREBOARD_EN
  logic [els_p-1:0] pending_r;
  logic [reg_w-1:0] rd_idx;

  assign rd_idx = reg_w'(cword_r.rd);
  assign hazard = ((rs1_idx != '0) && pending_r[rs1_idx] && ~|rs1_hit) ||
                  ((rs2_idx != '0) && pending_r[rs2_idx] && ~|rs2_hit);

  // Set is applied after the clears so a same-edge set/clear of one register leaves it pending;
  // a squashed instruction never claims its destination.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending_r <= '0;
    end else begin
      for (int unsigned p = 0; p < wb_ports_p; p++) begin
        if (wb_v_i[p]) pending_r[wb_rd[p]] <= 1'b0;
      end
      if (issue && !flush_i && cword_r.rd_w_v && (rd_idx != '0)) pending_r[rd_idx] <= 1'b1;
    end
  end
`else
  assign hazard = 1'b0;
`endif

endmodule

// File: tb/tb_rfetch_bypass_stage.sv
// Self-checking bench for rfetch_bypass_stage: slot/regfile model plus an issue-order scoreboard queue.
// Covers the RFETCH_SCOREBOARD_EN interlock too when that macro is defined.
module tb_rfetch_bypass_stage;
  import rvga_pkg::*;

  localparam int W  = 32;
  localparam int NP = 2;
  localparam int RW = 5;

  typedef struct {
    rvga_cword   cw;
    logic [31:0] imm;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_i = 1'b0;
  logic           v_i = 1'b0;
  logic           ready_o;
  rvga_cword      cword_i = '0;
  logic [24:0]    imm_raw_i = '0;
  logic           v_o;
  logic           ready_i = 1'b0;
  rvga_cword      cword_o;
  logic [W-1:0]   imm_data_o, rs1_data_o, rs2_data_o;
  logic           br_v_o;
  logic           flush_i = 1'b0;
  logic [NP-1:0]    wb_v_i;
  logic [NP*RW-1:0] wb_rd_i;
  logic [NP*W-1:0]  wb_data_i;

  logic           b_wv  [NP];
  logic [RW-1:0]  b_wrd [NP];
  logic [W-1:0]   b_wd  [NP];

  assign wb_v_i    = {b_wv[1], b_wv[0]};
  assign wb_rd_i   = {b_wrd[1], b_wrd[0]};
  assign wb_data_i = {b_wd[1], b_wd[0]};

  always #5 clk = ~clk;

  rfetch_bypass_stage #(.width_p(W), .els_p(32), .wb_ports_p(NP)) dut (
    .clk_i(clk), .rst_i(rst_i), .v_i(v_i), .ready_o(ready_o), .cword_i(cword_i),
    .imm_raw_i(imm_raw_i), .v_o(v_o), .ready_i(ready_i), .cword_o(cword_o),
    .imm_data_o(imm_data_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .br_v_o(br_v_o), .flush_i(flush_i), .wb_v_i(wb_v_i), .wb_rd_i(wb_rd_i),
    .wb_data_i(wb_data_i)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] rf_m [32];
  logic        m_valid;
  rvga_cword   m_cw;
  exp_t        q[$];
`ifdef RFETCH_SCOREBOARD_EN
  logic [31:0] pend_m;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] bimm(input rvga_cword c, input logic [24:0] raw);
    logic [31:0]        ins;
    logic signed [31:0] s;
    ins = {raw, 7'b0};
    s   = $signed(ins);
    case (c.inst_type)
      IT_I:    return c.shift_v ? {27'b0, ins[24:20]} : 32'(s >>> 20);
      IT_S:    return 32'((s >>> 25) <<< 5) | {27'b0, ins[11:7]};
      IT_B:    return 32'((s >>> 31) <<< 12) | {20'b0, ins[7], ins[30:25], ins[11:8], 1'b0};
      IT_U:    return ins & 32'hFFFF_F000;
      IT_J:    return 32'((s >>> 31) <<< 20) | {12'b0, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_byp(input logic [4:0] r);
    logic h;
    h = 1'b0;
    for (int p = 0; p < NP; p++) if (b_wv[p] && b_wrd[p] == r && r != 5'd0) h = 1'b1;
    return h;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    logic [31:0] v;
    if (r == 5'd0) return 32'h0;
    v = rf_m[r];
    for (int p = 0; p < NP; p++) if (b_wv[p] && b_wrd[p] == r) v = b_wd[p];
    return v;
  endfunction

`ifdef RFETCH_SCOREBOARD_EN
  function automatic logic m_haz(input rvga_cword c);
    return (c.rs1 != 5'd0 && pend_m[c.rs1] && !m_byp(c.rs1)) ||
           (c.rs2 != 5'd0 && pend_m[c.rs2] && !m_byp(c.rs2));
  endfunction
`endif

  function automatic rvga_cword mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd, input logic wv, input rvga_itype_e t,
                                   input logic sh, input logic br, input logic jmp);
    rvga_cword c;
    c.rs1 = rs1; c.rs2 = rs2; c.rd = rd; c.rd_w_v = wv;
    c.inst_type = t; c.shift_v = sh; c.br_v = br; c.jmp_v = jmp;
    return c;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_cw    = '0;
    for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
`ifdef RFETCH_SCOREBOARD_EN
    pend_m = 32'h0;
`endif
    q.delete();
  endtask

  task automatic set_wb(input int p, input logic v, input logic [4:0] rd, input logic [31:0] d);
    b_wv[p] = v; b_wrd[p] = rd; b_wd[p] = d;
  endtask

  task automatic clr_wb();
    for (int p = 0; p < NP; p++) set_wb(p, 1'b0, 5'd0, 32'h0);
  endtask

  // Check outputs mid-cycle, then advance the model across the coming edge.
  task automatic tick();
    logic m_vo, exp_ready, acc, iss;
    exp_t e;
    @(negedge clk);
    m_vo = m_valid;
`ifdef RFETCH_SCOREBOARD_EN
    if (m_haz(m_cw)) m_vo = 1'b0;
`endif
    exp_ready = !flush_i && (!m_valid || (m_vo && ready_i));
    check("v_o", 32'(v_o), 32'(m_vo));
    check("ready_o", 32'(ready_o), 32'(exp_ready));
    check("br_v_o", 32'(br_v_o), 32'(m_vo && (m_cw.br_v || m_cw.jmp_v)));
    check("cword_o", 32'(cword_o), 32'(m_cw));
    check("rs1_data", rs1_data_o, m_read(m_cw.rs1));
    check("rs2_data", rs2_data_o, m_read(m_cw.rs2));
    acc = v_i && exp_ready;
    iss = m_vo && ready_i;
    if (m_valid && (iss || flush_i) && q.size() > 0) begin
      e = q.pop_front();
      if (!flush_i) begin
        check("issue_cword", 32'(cword_o), 32'(e.cw));
        check("issue_imm", imm_data_o, e.imm);
      end
    end
`ifdef RFETCH_SCOREBOARD_EN
    for (int p = 0; p < NP; p++) if (b_wv[p]) pend_m[b_wrd[p]] = 1'b0;
    if (iss && !flush_i && m_cw.rd_w_v && m_cw.rd != 5'd0) pend_m[m_cw.rd] = 1'b1;
`endif
    for (int p = 0; p < NP; p++) if (b_wv[p] && b_wrd[p] != 5'd0) rf_m[b_wrd[p]] = b_wd[p];
    if (flush_i)  m_valid = 1'b0;
    else if (acc) m_valid = 1'b1;
    else if (iss) m_valid = 1'b0;
    if (acc) begin
      m_cw = cword_i;
      q.push_back('{cw: cword_i, imm: bimm(cword_i, imm_raw_i)});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rvga_itype_e tt [4] = '{IT_I, IT_S, IT_B, IT_J};
    rvga_cword   held;
    clr_wb();
    model_reset();

    // reset values while reset is held
    #12;
    check("rst_v_o", 32'(v_o), 32'h0);
    check("rst_ready_o", 32'(ready_o), 32'h1);
    check("rst_br_v_o", 32'(br_v_o), 32'h0);
    check("rst_cword_o", 32'(cword_o), 32'h0);
    check("rst_rs1", rs1_data_o, 32'h0);
    check("rst_rs2", rs2_data_o, 32'h0);
    check("rst_imm", imm_data_o, 32'h0);
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk); #1;

    // preload the register file; the last port-1 write targets x0 and must be dropped
    for (int r = 1; r < 32; r += 2) begin
      set_wb(0, 1'b1, 5'(r), 32'h1000_0000 + 32'(r) * 32'h111);
      set_wb(1, 1'b1, 5'(r + 1), 32'h2000_0000 + 32'(r + 1) * 32'h111);
      tick();
    end
    clr_wb();

    // four back-to-back instructions with full downstream acceptance
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      v_i       = 1'b1;
      cword_i   = mk(5'(i + 1), 5'(i + 9), 5'(i + 20), 1'b1, tt[i], 1'b0,
                     tt[i] == IT_B, tt[i] == IT_J);
      imm_raw_i = 25'($urandom);
      tick();
    end
    v_i = 1'b0;
    tick(); tick();

    // two ports write x5 together: highest port wins, then the array holds it
    ready_i = 1'b0; v_i = 1'b1;
    held = mk(5'd5, 5'd0, 5'd0, 1'b0, IT_U, 1'b0, 1'b0, 1'b0);
    cword_i = held; imm_raw_i = 25'h1ABCDEF;
    tick();
    v_i = 1'b0;
    set_wb(0, 1'b1, 5'd5, 32'h0000_AAAA);
    set_wb(1, 1'b1, 5'd5, 32'h0000_5555);
    #3 check("byp_prio_rs1", rs1_data_o, 32'h0000_5555);
    tick();
    clr_wb();
    #3 check("array_rs1", rs1_data_o, 32'h0000_5555);
    tick();

    // write to x0 is neither stored nor bypassed
    set_wb(0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #3 check("x0_rs2", rs2_data_o, 32'h0);
    tick();
    clr_wb();

    // backpressure holds the slot, then flush squashes it and refuses the newcomer
    v_i = 1'b1;
    cword_i = mk(5'd6, 5'd7, 5'd8, 1'b1, IT_S, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #3 check("bp_ready_o", 32'(ready_o), 32'h0);
      check("bp_cword_hold", 32'(cword_o), 32'(held));
      tick();
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; v_i = 1'b0;
    #3 check("flush_v_o", 32'(v_o), 32'h0);
    check("flush_no_accept", 32'(cword_o), 32'(held));
    tick();

    // asynchronous reset with an instruction held
    v_i = 1'b1;
    cword_i = mk(5'd3, 5'd4, 5'd0, 1'b0, IT_I, 1'b0, 1'b1, 1'b0);
    tick();
    v_i = 1'b0;
    #2 rst_i = 1'b0;
    #1 check("arst_v_o", 32'(v_o), 32'h0);
    check("arst_ready_o", 32'(ready_o), 32'h1);
    check("arst_rs1", rs1_data_o, 32'h0);
    model_reset();
    @(negedge clk); rst_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b1; v_i = 1'b1;
    cword_i = mk(5'd1, 5'd2, 5'd0, 1'b0, IT_J, 1'b0, 1'b0, 1'b1);
    imm_raw_i = 25'h155AA33;
    tick();
    v_i = 1'b0;
    #3 check("post_rst_v_o", 32'(v_o), 32'h1);
    tick();

`ifdef RFETCH_SCOREBOARD_EN
    // writer to x7 issues, the following reader of x7 stalls until the writeback pulse
    ready_i = 1'b1; v_i = 1'b1;
    cword_i = mk(5'd1, 5'd2, 5'd7, 1'b1, IT_R, 1'b0, 1'b0, 1'b0);
    tick();
    cword_i = mk(5'd7, 5'd0, 5'd0, 1'b0, IT_R, 1'b0, 1'b0, 1'b0);
    tick();
    v_i = 1'b0;
    #3 check("sb_stall", 32'(v_o), 32'h0);
    tick(); tick();
    #3 check("sb_stall_hold", 32'(v_o), 32'h0);
    set_wb(0, 1'b1, 5'd7, 32'h000C_0DE7);
    #1 check("sb_release", 32'(v_o), 32'h1);
    check("sb_byp_rs1", rs1_data_o, 32'h000C_0DE7);
    tick();
    clr_wb();
    tick();
`endif

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      v_i       = ($urandom_range(0, 3) != 0);
      ready_i   = ($urandom_range(0, 3) != 0);
      flush_i   = ($urandom_range(0, 15) == 0);
      cword_i   = mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     rvga_itype_e'(3'($urandom_range(0, 5))), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      imm_raw_i = 25'($urandom);
      for (int p = 0; p < NP; p++)
        set_wb(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      tick();
    end
    v_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    clr_wb();
    for (int i = 0; i < 4; i++) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
